// File: rtl/serial_pkg.sv
// Shared constants and helpers for the serial shift register family.
package serial_pkg;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Width of a counter that must hold 0..width-1, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Counts accepted shifts modulo WIDTH and emits a registered pulse on each wrap.
module serial_bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW   = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          wrap_pulse
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      wrap_pulse <= 1'b0;
    end else if (clr) begin
      cnt        <= '0;
      wrap_pulse <= 1'b0;
    end else if (inc) begin
      cnt        <= (cnt == LAST) ? '0 : cnt + 1'b1;
      wrap_pulse <= (cnt == LAST);
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_shift_param.sv
// WIDTH-bit bidirectional serial shift register with parallel load and word pulse.
// Optional rotate mode (input rot) is enabled by defining SERIAL_SHIFT_ROTATE_EN.
module serial_shift_param
  import serial_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             sin,
  input  logic             load,
  input  logic [WIDTH-1:0] pin,
`ifdef SERIAL_SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic             sout,
  output logic [WIDTH-1:0] pout,
  output logic             word_done
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_shifted;
  logic             fill;
  logic [CW-1:0]    cnt;

  assign sout = (dir == DIR_LEFT) ? q[WIDTH-1] : q[0];

  // In rotate mode the ejected bit is exactly what re-enters at the far end.
`ifdef SERIAL_SHIFT_ROTATE_EN
  assign fill = rot ? sout : sin;
`else
  assign fill = sin;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    q_shifted = q;
    if (dir == DIR_LEFT) q_shifted = {q[WIDTH-2:0], fill};
    else                 q_shifted = {fill, q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst)          q <= RESET_VAL;
    else if (load)     q <= pin;
    else if (shift_en) q <= q_shifted;
  end

  assign pout = q;

  serial_bit_counter #(.WIDTH(WIDTH)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        (load),
    .inc        (shift_en & ~load),
    .cnt        (cnt),
    .wrap_pulse (word_done)
  );

  // A word pulse always coincides with a freshly wrapped counter.
  assert property (@(posedge clk) disable iff (!rst) word_done |-> (cnt == '0));

endmodule
